// File: rtl/stack_ctrl.sv
// Stack controller for the CPU scratch stack.
// It owns the stack pointer and drives a single-port synchronous stack RAM.
// It accepts one PUSH/POP/PEEK/CLEAR command at a time and returns one
// response pulse per command.
module stack_ctrl #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [AW:0]   depth,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wen,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned SPW = AW + 1;
  localparam int unsigned CW  = 3;
  localparam logic [AW:0]   DEPTH_V  = SPW'(1) << AW;
  localparam logic [CW-1:0] LAT_LAST = CW'(RD_LAT);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RDWAIT,
    ST_RESP
  } state_t;

  state_t        state;
  logic [AW:0]   sp;
  logic [CW-1:0] lat_cnt;
  logic          err_q;
  logic [AW:0]   sp_dec;

  // Occupancy flags and the address of the top entry
  assign sp_dec = sp - SPW'(1);
  assign depth  = sp;
  assign empty  = (sp == '0);
  assign full   = (sp == DEPTH_V);

  // Command sequencer: RESP shares the handshake slot with IDLE, so a new
  // command can be accepted at the edge that ends the response cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      sp        <= '0;
      lat_cnt   <= '0;
      err_q     <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      ram_wen   <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_PUSH: begin
                if (full) begin
                  err_q <= 1'b1;
                  state <= ST_RESP;
                end else begin
                  err_q     <= 1'b0;
                  ram_addr  <= sp[AW-1:0];
                  ram_wdata <= cmd_data;
                  ram_wen   <= 1'b1;
                  sp        <= sp + SPW'(1);
                  state     <= ST_WRITE;
                end
              end
              OP_POP, OP_PEEK: begin
                if (empty) begin
                  err_q <= 1'b1;
                  state <= ST_RESP;
                end else begin
                  err_q    <= 1'b0;
                  ram_addr <= sp_dec[AW-1:0];
                  if (cmd_op == OP_POP) begin
                    sp <= sp_dec;
                  end
                  lat_cnt <= '0;
                  state   <= ST_RDWAIT;
                end
              end
              default: begin
                sp    <= '0;
                err_q <= 1'b0;
                state <= ST_RESP;
              end
            endcase
          end
        end
        ST_WRITE, ST_RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_data  <= '0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_RDWAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= ram_rdata;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl.
// u0: AW=2, RD_LAT=1.  u1: AW=8, RD_LAT=3.  Each instance has its own RAM model.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        sel;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;

  logic        r0_ready, r0_valid, r0_err, r0_empty, r0_full, r0_wen;
  logic [31:0] r0_data, r0_wdata, r0_rdata;
  logic [2:0]  r0_depth;
  logic [1:0]  r0_addr;

  logic        r1_ready, r1_valid, r1_err, r1_empty, r1_full, r1_wen;
  logic [31:0] r1_data, r1_wdata, r1_rdata, s1a, s1b;
  logic [8:0]  r1_depth;
  logic [7:0]  r1_addr;

  logic        o_ready, o_valid, o_err, o_empty, o_full;
  logic [31:0] o_data;
  logic [8:0]  o_depth;

  logic [31:0] mem0 [4];
  logic [31:0] mem1 [256];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          depth;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wen0_cnt = 0;
  int   wen1_cnt = 0;
  int   wen_dbl = 0;
  logic w0_prev = 1'b0;
  logic w1_prev = 1'b0;

  always #5 clk = ~clk;

  stack_ctrl #(.AW(2), .DW(32), .RD_LAT(1)) u0 (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid & ~sel), .cmd_ready(r0_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(r0_valid), .rsp_data(r0_data),
    .rsp_err(r0_err), .depth(r0_depth), .empty(r0_empty), .full(r0_full),
    .ram_addr(r0_addr), .ram_wdata(r0_wdata), .ram_wen(r0_wen), .ram_rdata(r0_rdata)
  );

  stack_ctrl #(.AW(8), .DW(32), .RD_LAT(3)) u1 (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid & sel), .cmd_ready(r1_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(r1_valid), .rsp_data(r1_data),
    .rsp_err(r1_err), .depth(r1_depth), .empty(r1_empty), .full(r1_full),
    .ram_addr(r1_addr), .ram_wdata(r1_wdata), .ram_wen(r1_wen), .ram_rdata(r1_rdata)
  );

  // Single-port RAM models: 1-cycle and 3-cycle registered reads
  always @(posedge clk) begin
    if (r0_wen) mem0[r0_addr] <= r0_wdata;
    r0_rdata <= mem0[r0_addr];
    if (r1_wen) mem1[r1_addr] <= r1_wdata;
    s1a      <= mem1[r1_addr];
    s1b      <= s1a;
    r1_rdata <= s1b;
  end

  // Count write pulses and flag any write enable held for two cycles
  always @(negedge clk) begin
    if (r0_wen) wen0_cnt <= wen0_cnt + 1;
    if (r1_wen) wen1_cnt <= wen1_cnt + 1;
    if ((r0_wen && w0_prev) || (r1_wen && w1_prev)) wen_dbl <= wen_dbl + 1;
    w0_prev <= r0_wen;
    w1_prev <= r1_wen;
  end

  // Observe whichever instance is selected
  always_comb begin
    o_ready = sel ? r1_ready : r0_ready;
    o_valid = sel ? r1_valid : r0_valid;
    o_err   = sel ? r1_err   : r0_err;
    o_data  = sel ? r1_data  : r0_data;
    o_depth = sel ? r1_depth : {6'd0, r0_depth};
    o_empty = sel ? r1_empty : r0_empty;
    o_full  = sel ? r1_full  : r0_full;
  end

  // Issue one command, queue the expected response, then check it when it appears
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_depth);
    exp_t e;
    int   k;
    bit   got;
    k = 0;
    while (o_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout op=%0d got ready=%b want 1", op, o_ready);
      return;
    end
    e.data  = exp_d;
    e.err   = exp_e;
    e.depth = exp_depth;
    e.lat   = (exp_e || op == 2'b00 || op == 2'b11) ? 1 : (sel ? 4 : 2);
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (o_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        checks++;
        if (o_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_busy op=%0d cycle=%0d got %b want 0", op, k, o_ready);
        end
      end
    end
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rsp_timeout op=%0d no rsp_valid within %0d cycles", op, k);
      return;
    end
    if (k != e.lat) begin
      errors++;
      $display("FAIL rsp_latency op=%0d got %0d want %0d", op, k, e.lat);
    end
    checks++;
    if (o_data !== e.data) begin
      errors++;
      $display("FAIL rsp_data op=%0d got %h want %h", op, o_data, e.data);
    end
    checks++;
    if (o_err !== e.err) begin
      errors++;
      $display("FAIL rsp_err op=%0d got %b want %b", op, o_err, e.err);
    end
    checks++;
    if (o_depth !== 9'(e.depth)) begin
      errors++;
      $display("FAIL depth op=%0d got %0d want %0d", op, o_depth, e.depth);
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_with_rsp op=%0d got %b want 1", op, o_ready);
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    sel       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({r0_ready, r0_valid, r0_err, r0_wen} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got rdy/vld/err/wen=%b want 0000",
               {r0_ready, r0_valid, r0_err, r0_wen});
    end
    checks++;
    if (r0_depth !== 3'd0 || r0_empty !== 1'b1 || r0_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_depth got depth=%0d empty=%b full=%b want 0 1 0",
               r0_depth, r0_empty, r0_full);
    end
    checks++;
    if (r0_addr !== 2'd0 || r0_data !== 32'd0 || r0_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs got addr=%0d rdata=%h wdata=%h want 0",
               r0_addr, r0_data, r0_wdata);
    end
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b%b want 11", r0_ready, r1_ready);
    end
  endtask

  task automatic test_push_pop();
    int w;
    w = wen0_cnt;
    do_cmd(2'b00, 32'h11, 32'h0, 1'b0, 1);
    do_cmd(2'b00, 32'h22, 32'h0, 1'b0, 2);
    do_cmd(2'b00, 32'h33, 32'h0, 1'b0, 3);
    do_cmd(2'b01, 32'h0, 32'h33, 1'b0, 2);
    do_cmd(2'b01, 32'h0, 32'h22, 1'b0, 1);
    do_cmd(2'b01, 32'h0, 32'h11, 1'b0, 0);
    checks++;
    if (wen0_cnt - w != 3) begin
      errors++;
      $display("FAIL wen_pulses got %0d want 3", wen0_cnt - w);
    end
  endtask

  task automatic test_empty();
    int w;
    w = wen0_cnt;
    do_cmd(2'b01, 32'h0, 32'h0, 1'b1, 0);
    do_cmd(2'b10, 32'h0, 32'h0, 1'b1, 0);
    checks++;
    if (wen0_cnt != w) begin
      errors++;
      $display("FAIL empty_no_write got %0d writes want 0", wen0_cnt - w);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) do_cmd(2'b00, 32'(i), 32'h0, 1'b0, i);
    do_cmd(2'b00, 32'd5, 32'h0, 1'b1, 4);
    checks++;
    if (o_full !== 1'b1) begin
      errors++;
      $display("FAIL full_flag got %b want 1", o_full);
    end
    do_cmd(2'b01, 32'h0, 32'd4, 1'b0, 3);
    do_cmd(2'b11, 32'h0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_peek_clear();
    do_cmd(2'b00, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    do_cmd(2'b10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    do_cmd(2'b10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    do_cmd(2'b11, 32'h0, 32'h0, 1'b0, 0);
    checks++;
    if (o_empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_after_clear got %b want 1", o_empty);
    end
    do_cmd(2'b10, 32'h0, 32'h0, 1'b1, 0);
  endtask

  task automatic test_read_latency();
    @(negedge clk);
    sel = 1'b1;
    do_cmd(2'b00, 32'hA5, 32'h0, 1'b0, 1);
    do_cmd(2'b01, 32'h0, 32'hA5, 1'b0, 0);
  endtask

  task automatic test_reset_midop();
    bit seen;
    do_cmd(2'b00, 32'h99, 32'h0, 1'b0, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_depth !== 9'd0) begin
      errors++;
      $display("FAIL midop_reset got vld=%b rdy=%b depth=%0d want 0 0 0",
               o_valid, o_ready, o_depth);
    end
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_depth !== 9'd0) begin
      errors++;
      $display("FAIL midop_release got rdy=%b depth=%0d want 1 0", o_ready, o_depth);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (o_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midop_stray_rsp got rsp_valid=1 want 0");
    end
    do_cmd(2'b00, 32'h7, 32'h0, 1'b0, 1);
    do_cmd(2'b01, 32'h0, 32'h7, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_empty();
    test_overflow();
    test_peek_clear();
    test_read_latency();
    test_reset_midop();
    checks++;
    if (wen_dbl != 0) begin
      errors++;
      $display("FAIL wen_single_cycle got %0d double pulses want 0", wen_dbl);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
